// File: rtl/weight_stream_loader.sv
// weight_stream_loader: converts a byte-wide valid/ready weight stream into
// the serial copy/k shift interface of the encoder weight register. Each
// word is shifted out LSB first. Exactly WEIGHTS_B shift cycles are issued
// per load, followed by a one-cycle done pulse.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no load in progress, waiting for start
//   FILL  | shift buffer empty, waiting for the next stream word
//   SHIFT | copy=1, shifting buffer bits out, refilled on the last bit
//   DONE  | final bit shifted, done pulse for one cycle
module weight_stream_loader #(
  parameter int WEIGHTS_B = 10496,
  parameter int IN_W      = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            abort,
  input  logic [IN_W-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            copy,
  output logic            k,
  output logic            busy,
  output logic            done
);

  localparam int WORDS = WEIGHTS_B / IN_W;
  localparam int BC_W  = $clog2(IN_W + 1);
  localparam int WC_W  = $clog2(WORDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q;
  logic [IN_W-1:0] shbuf_q;
  logic [BC_W-1:0] bit_cnt_q;
  logic [WC_W-1:0] word_cnt_q;

  logic last_bit;
  logic last_word;
  logic accept;

  assign last_bit  = (bit_cnt_q == BC_W'(1));
  assign last_word = (word_cnt_q == WC_W'(WORDS));

  // Ready depends only on flops: in FILL, or on the final bit of a word
  // that is not the last of the load (gives back-to-back words, no bubble).
  assign s_ready = (state_q == FILL) ||
                   ((state_q == SHIFT) && last_bit && !last_word);
  assign accept  = s_valid && s_ready;

  // All outputs are decoded straight from flops; no input reaches copy or k.
  assign copy = (state_q == SHIFT);
  assign k    = shbuf_q[0];
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // Load sequencer: state, shift buffer and word/bit counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      shbuf_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else if (abort) begin
      // Abort also wins over start in IDLE; the encoder keeps what it has.
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FILL;
            word_cnt_q <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            shbuf_q    <= s_data;
            bit_cnt_q  <= BC_W'(IN_W);
            word_cnt_q <= word_cnt_q + WC_W'(1);
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          shbuf_q   <= shbuf_q >> 1;
          bit_cnt_q <= bit_cnt_q - BC_W'(1);
          if (last_bit) begin
            if (last_word) begin
              state_q <= DONE;
            end else if (accept) begin
              shbuf_q    <= s_data;
              bit_cnt_q  <= BC_W'(IN_W);
              word_cnt_q <= word_cnt_q + WC_W'(1);
            end else begin
              state_q <= FILL;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Bench for weight_stream_loader: drives randomized byte streams with
// optional stalls, abort, restart attempts and async reset, and compares the
// serial output against an LSB-first unpacking of the bytes plus a model of
// the downstream shift register.
module tb_weight_stream_loader;

  localparam int WEIGHTS_B = 10496;
  localparam int IN_W      = 8;
  localparam int WORDS     = WEIGHTS_B / IN_W;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic            abort;
  logic [IN_W-1:0] s_data;
  logic            s_valid;
  logic            s_ready;
  logic            copy;
  logic            k;
  logic            busy;
  logic            done;

  weight_stream_loader #(.WEIGHTS_B(WEIGHTS_B), .IN_W(IN_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .abort   (abort),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .copy    (copy),
    .k       (k),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Reference data for the current load.
  logic [IN_W-1:0]      data [WORDS];
  logic [WEIGHTS_B-1:0] exp_vec;
  logic [WEIGHTS_B-1:0] wmodel;
  logic [15:0]          first16;

  // Observation statistics, updated on every falling edge.
  int cyc = 0;
  int start_cyc, copy_cnt, done_cnt, done_cyc, first_copy, last_copy;
  int runs, run_len, first_run, first_gap, cur_gap, bad_runs, kerr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic clear_stats();
    start_cyc = -1; copy_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_copy = -1; last_copy = -1; runs = 0; run_len = 0;
    first_run = 0; first_gap = 0; cur_gap = 0; bad_runs = 0; kerr = 0;
    wmodel = '0; first16 = '0;
  endtask

  // Monitor: expected k is bit copy_cnt of the LSB-first unpacked stream.
  initial begin
    clear_stats();
    forever begin
      @(negedge clk);
      cyc++;
      if (start && !busy) start_cyc = cyc;
      if (copy) begin
        if (run_len == 0) begin
          runs++;
          if (runs == 2) first_gap = cur_gap;
        end
        run_len++;
        if (copy_cnt < WEIGHTS_B) begin
          if (k !== exp_vec[copy_cnt]) kerr++;
          if (copy_cnt < 16) first16[copy_cnt] = k;
        end else begin
          kerr++;
        end
        wmodel = {k, wmodel[WEIGHTS_B-1:1]};
        if (copy_cnt == 0) first_copy = cyc;
        last_copy = cyc;
        copy_cnt++;
      end else begin
        if (run_len > 0) begin
          if (runs == 1) first_run = run_len;
          if (run_len % IN_W != 0) bad_runs++;
          run_len = 0;
          cur_gap = 0;
        end
        cur_gap++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // mode 0: byte n = n mod 256; 1: random; 2: 0x01, 0x80, then random.
  // abort_after / stop_after / restart_at / stall_after are word counts (-1 = off).
  task automatic run_load(input int mode, input int abort_after, input int stop_after,
                          input int restart_at, input int stall_after,
                          input int stall_len, input int rnd_pct);
    int n = 0;
    int stall_rem = 0;
    int guard = 0;
    bit hs;
    bit drop;
    bit early = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      if (mode == 0) data[i] = IN_W'(i);
      else           data[i] = IN_W'($urandom_range(0, 255));
    end
    if (mode == 2) begin
      data[0] = 8'h01;
      data[1] = 8'h80;
    end
    for (int i = 0; i < WORDS; i++)
      for (int j = 0; j < IN_W; j++)
        exp_vec[i*IN_W + j] = data[i][j];
    clear_stats();

    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    while (n < WORDS && guard < 20000) begin
      guard++;
      drop = (stall_rem > 0) ||
             (rnd_pct > 0 && int'($urandom_range(0, 99)) < rnd_pct);
      s_valid = !drop;
      s_data  = data[n];
      @(negedge clk);
      hs = s_valid && s_ready;
      if (stall_rem > 0 && s_ready) stall_rem--;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) begin
        n++;
        if (n == stall_after) stall_rem = stall_len;
        if (n == restart_at) start = 1'b1;
        if (n == abort_after) begin
          abort   = 1'b1;
          s_valid = 1'b0;
          @(posedge clk); #1;
          abort = 1'b0;
          chk("abort_busy", busy, 0);
          chk("abort_copy", copy, 0);
          early = 1'b1;
          break;
        end
        if (n == stop_after) begin
          s_valid = 1'b0;
          early   = 1'b1;
          break;
        end
      end
    end
    s_valid = 1'b0;
    if (!early) begin
      chk("words_accepted", n, WORDS);
      for (int w = 0; w < 40 && done_cnt == 0; w++) @(negedge clk);
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic check_full(input bit tight);
    chk("copy_cycles", copy_cnt, WEIGHTS_B);
    chk("done_pulses", done_cnt, 1);
    chk("done_after_last_copy", done_cyc - last_copy, 1);
    chk("k_sequence_errors", kerr, 0);
    chk("shift_model", 32'(wmodel === exp_vec), 1);
    chk("runs_word_multiple", bad_runs, 0);
    if (tight) begin
      chk("copy_runs", runs, 1);
      chk("first_copy_latency", first_copy - start_cyc, 2);
      chk("done_latency", done_cyc - start_cyc, WEIGHTS_B + 2);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    #2;
    chk("rst_copy", copy, 0);
    chk("rst_k", k, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // abort beats start in IDLE
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; s_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    chk("abort_start_idle_busy", busy, 0);
    chk("abort_start_idle_ready", s_ready, 0);

    // full load, byte n = n mod 256, continuous valid
    run_load(0, -1, -1, -1, -1, 0, 0);
    check_full(1'b1);

    // bit order with random stalls
    run_load(2, -1, -1, -1, -1, 0, 12);
    check_full(1'b0);
    chk("bit_order_first16", first16, 16'h8001);

    // 5-cycle stall after word 3
    run_load(1, -1, -1, -1, 3, 5, 0);
    check_full(1'b0);
    chk("stall_runs", runs, 2);
    chk("stall_first_run", first_run, 3 * IN_W);
    chk("stall_gap", first_gap, 5);

    // abort after 100 words: word 100 shifts one bit before the abort lands
    run_load(1, 100, -1, -1, -1, 0, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_ready_low", s_ready, 0);
    chk("abort_copy_cycles", copy_cnt, 99 * IN_W + 1);
    chk("abort_k_errors", kerr, 0);

    // full load after abort, with a start pulse at word 500
    run_load(1, -1, -1, 500, -1, 0, 0);
    check_full(1'b1);

    // async reset mid-SHIFT
    run_load(1, -1, 10, -1, -1, 0, 0);
    #2;
    chk("pre_reset_copy", copy, 1);
    rstn = 1'b0;
    #1;
    chk("async_copy", copy, 0);
    chk("async_k", k, 0);
    chk("async_ready", s_ready, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_ready", s_ready, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_no_done", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/weight_stream_loader.md
Name: weight_stream_loader

Overview:
- Upstream stage of the small-encoder inference block. It turns a byte-wide valid/ready weight stream into the serial `copy`/`k` shift interface that loads the encoder's WEIGHTS_B-bit weight register.
- It counts words and bits so that exactly WEIGHTS_B shift cycles are issued per load, then signals completion.
- It tolerates upstream stalls, and a load can be aborted.

Parameters:
- WEIGHTS_B, 10496, total weight bits shifted per load. Must be a multiple of IN_W.
- IN_W, 8, width of one input stream word.
- WORDS, WEIGHTS_B/IN_W (localparam, 1312), words per load.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load. Honoured only in IDLE.
- abort  input  1  synchronous cancel of an in-progress load.
- s_data  input  IN_W  stream word.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts s_data this cycle.
- copy  output  1  shift enable to the encoder weight register.
- k  output  1  serial weight bit, meaningful when copy=1.
- busy  output  1  load in progress (state != IDLE).
- done  output  1  one-cycle pulse when the final bit has been shifted.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; shift buffer, bit_cnt and word_cnt all 0.
  - All outputs are 0 at reset.
  - Reset mid-load drops the load with no done pulse. The encoder keeps its partially shifted contents.
- Registered signals:
  - copy = (state==SHIFT), decoded from the state flop.
  - k = buf[0], taken directly from a flop.
  - No combinational path from any input to copy or k.
- States:
  - IDLE: s_ready=0, copy=0. start=1 -> FILL; word_cnt<=0.
  - FILL: s_ready=1, copy=0. On s_valid&s_ready: buf<=s_data, bit_cnt<=IN_W, word_cnt<=word_cnt+1, -> SHIFT.
  - SHIFT: copy=1, k=buf[0]. Each cycle buf<=buf>>1 and bit_cnt<=bit_cnt-1.
    - On the last bit (bit_cnt==1):
      - word_cnt==WORDS -> DONE.
      - Otherwise, s_ready=1. If s_valid, load the next word and stay in SHIFT with no bubble; if not, -> FILL.
    - s_ready=0 in SHIFT at all other times.
  - DONE: done=1 for one cycle, copy=0, -> IDLE.
- Bit order:
  - Words are LSB first: word i, bit j is the (i*IN_W+j)-th bit shifted.
  - After a full load, that bit sits at encoder weight index i*IN_W+j, because the first bit shifted ends at index 0.
- Latency and throughput:
  - A word accepted at edge t gives copy=1 in cycles t+1 .. t+IN_W.
  - With continuous s_valid, copy stays high for WEIGHTS_B consecutive cycles.
  - done is asserted in the cycle after the last copy=1 cycle.
- Stalls: s_valid=0 while s_ready=1 holds FILL with copy=0. Shifting resumes one cycle after acceptance.
- start:
  - Ignored when state != IDLE.
  - start and s_valid in the same IDLE cycle: no word is accepted, since s_ready=0 in IDLE.
- abort (any non-IDLE state) -> IDLE next cycle.
  - copy=0 and s_ready=0 from that next cycle onward.
  - The handshake in the abort cycle itself is still honoured per the rules above.
  - No done pulse.
  - abort and start in the same IDLE cycle: abort wins and the state stays IDLE.
- Counter widths:
  - bit_cnt is $clog2(IN_W+1) bits.
  - word_cnt is $clog2(WORDS+1) bits.
  - Neither counter wraps during a load.

Test Plan:
- Full load: start, then 1312 bytes with continuous s_valid (byte n = n mod 256).
  - copy is high for exactly 10496 consecutive cycles.
  - done pulses once, 1 cycle after the last copy cycle.
  - The captured k sequence matches the LSB-first unpacking.
  - The downstream 10496-bit shift model equals the concatenated bytes.
- Bit order: first byte 0x01, then 0x80.
  - k sequence is 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1.
- Stall: s_valid low for 5 cycles after word 3.
  - copy drops for the stall cycles only.
  - Total copy-high cycles is still 10496; done pulses once.
- Abort: abort asserted after 100 words.
  - busy=0 and copy=0 next cycle, no done pulse.
  - A subsequent start performs a full, correct load.
- start while busy: pulse start at word 500.
  - No restart; word_cnt continues, and done occurs at the normal cycle.
- Async reset: rstn low mid-SHIFT.
  - copy, k, s_ready, busy and done go 0 immediately, without waiting for a clock edge.
  - After release, state is IDLE and s_ready stays 0 until start.
